qam16_nibble_packer: RTL and testbench
======================================

Name: qam16_nibble_packer

Overview:
- Downstream consumer of the 16-QAM demapper.
- Accepts one 4-bit demapped symbol per handshake, pairs consecutive symbols into bytes, and buffers the bytes in a small FIFO.
- Presents the bytes to the byte-oriented descrambler/deinterleaver side of the OFDM receive chain over a valid/ready interface.
- Decouples the symbol-rate demapper output from byte-side backpressure.

Parameters:
- FIFO_DEPTH, 4, number of byte entries; power of two, >= 2.
- MSB_FIRST, 1, 1: first nibble of a pair goes to byte[7:4]; 0: first nibble goes to byte[3:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  demapped symbol present.
- sym_ready  out  1  packer can accept a symbol.
- sym_bits  in  4  demapped_bits from the demapper.
- byte_valid  out  1  FIFO head holds a byte.
- byte_ready  in  1  downstream accepts byte.
- byte_data  out  8  FIFO head byte.
- byte_pad  out  1  low/second nibble of byte_data is zero padding (flush-generated).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently stored.
- flush  in  1  only with QAM_PACK_FLUSH_EN; emit a held half-byte.

Behaviour:
- Reset: async assert, sync release. State=S_FIRST; FIFO empty. Outputs: byte_valid=0, byte_data=0x00, byte_pad=0, fifo_level=0, sym_ready=1. The holding nibble register clears to 0.
- Symbol handshake: sym_valid && sym_ready at a rising edge. Byte handshake: byte_valid && byte_ready at a rising edge.
- FSM:
  - S_FIRST: sym handshake stores sym_bits in hold_nib, then goes to S_SECOND. No FIFO write.
  - S_SECOND: sym handshake forms the byte and writes it to the FIFO tail, then goes to S_FIRST.
    - MSB_FIRST=1: byte = {hold_nib, sym_bits}.
    - MSB_FIRST=0: byte = {sym_bits, hold_nib}.
    - byte_pad written as 0.
- sym_ready = (state==S_FIRST) || (fifo_level < FIFO_DEPTH).
  - Registered-state function only; no combinational path from byte_ready.
- Latency: when the FIFO is empty, the byte completed at edge N appears as byte_valid=1 with correct byte_data in the cycle after edge N. No bypass path.
- byte_valid = (fifo_level != 0). byte_data/byte_pad are driven from the FIFO head.
  - While byte_valid=1 and byte_ready=0, byte_data and byte_pad stay stable.
  - When empty, byte_data and byte_pad hold their last value. Don't-care for checking; must not be X after reset.
- Byte handshake pops the head, advances rd_ptr, and decrements the level.
- Simultaneous push and pop in one cycle: level unchanged, both pointers advance.
  - Allowed at any level, including FIFO_DEPTH-1.
  - At level == FIFO_DEPTH no push occurs, because sym_ready=0 in S_SECOND.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The level counter saturates at neither bound; pushes and pops are legal-only by construction.
- sym_valid while sym_ready=0: the symbol is not consumed and no state change occurs. The upstream must hold the data.
- Reset mid-operation: any held nibble and all FIFO content are discarded. The next symbol after release is treated as a first nibble.

Optional Feature:
- Macro: QAM_PACK_FLUSH_EN.
- Defined:
  - flush port exists.
  - In S_SECOND, with flush=1, no sym handshake that cycle, and fifo_level < FIFO_DEPTH: push a padded byte with byte_pad=1, then go to S_FIRST.
    - MSB_FIRST=1: byte is {hold_nib, 4'h0}.
    - MSB_FIRST=0: byte is {4'h0, hold_nib}.
  - flush during a sym handshake in S_SECOND is ignored; the normal byte completes.
  - flush in S_FIRST has no effect.
  - flush with a full FIFO waits; the requester holds flush.
- Undefined: no flush port; byte_pad is constant 0 and may be optimised away.

Test Plan:
- MSB_FIRST=1, byte_ready=1: symbols 0x3, 0xA, 0xF, 0x0 -> bytes 0x3A, then 0xF0, each valid one cycle after its second nibble; byte_pad=0.
- MSB_FIRST=0: symbols 0x3, 0xA -> byte 0xA3.
- FIFO_DEPTH=4, byte_ready=0, sym_valid held high with 10 distinct nibbles:
  - 9 accepted (4 bytes plus 1 held); sym_ready=0 on the 10th; fifo_level=4.
  - Raise byte_ready -> 4 bytes drain in order, and the 10th nibble completes byte 5.
- Level 2, push and pop in the same cycle -> fifo_level stays 2; order preserved across pointer wrap over 12 bytes.
- Send 0x7, then pulse rst_n low mid-cycle -> outputs reset immediately; then 0x1, 0x2 -> single byte 0x12.
- QAM_PACK_FLUSH_EN, MSB_FIRST=1:
  - 0x5, then flush -> byte 0x50 with byte_pad=1.
  - flush in S_FIRST -> no byte.
  - flush with 2nd-nibble handshake 0xC after 0x5 -> byte 0x5C, pad=0.

Source files
------------

// File: rtl/qam16_nibble_packer.sv
// qam16_nibble_packer
//   Pairs consecutive 4-bit 16-QAM demapped symbols into bytes and buffers
//   them in a small FIFO for the byte-oriented descrambler/deinterleaver.
//   The FIFO decouples the symbol-rate demapper from byte-side backpressure.
//
// Parameters
//   FIFO_DEPTH : number of byte entries (power of two, >= 2)
//   MSB_FIRST  : 1 = first nibble of a pair lands in byte[7:4],
//                0 = first nibble lands in byte[3:0]
//
// Ports
//   clk, rst_n             : clock (rising edge), async active-low reset
//   sym_valid/sym_ready    : symbol handshake, sym_bits carries the nibble
//   byte_valid/byte_ready  : byte handshake, byte_data is the FIFO head
//   byte_pad               : low/second nibble of byte_data is flush padding
//   fifo_level             : number of bytes currently stored
//   flush                  : only with QAM_PACK_FLUSH_EN; emits a held nibble
//
// Build option
//   QAM_PACK_FLUSH_EN : adds the flush port and padded-byte generation.
//                       Without it byte_pad is constant 0.
//
// state    | meaning
// S_FIRST  | waiting for the first nibble of a byte
// S_SECOND | first nibble held in hold_nib, waiting for the second
module qam16_nibble_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  input  logic [3:0]                    sym_bits,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [7:0]                    byte_data,
  output logic                          byte_pad,
`ifdef QAM_PACK_FLUSH_EN
  input  logic                          flush,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic {S_FIRST, S_SECOND} state_t;

  state_t          state_q, state_d;
  logic [3:0]      hold_nib_q, hold_nib_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  // Each entry is {pad, data}
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [8:0]      mem_d [FIFO_DEPTH];

  logic            sym_hs;
  logic            byte_hs;
  logic            push;
  logic            pop;
  logic [7:0]      push_data;
  logic            push_pad;
  logic            not_full;

  // Registered-state functions only: byte_ready never reaches sym_ready.
  assign not_full   = (level_q < DEPTH_L);
  assign sym_ready  = (state_q == S_FIRST) || not_full;
  assign byte_valid = (level_q != '0);
  assign byte_data  = mem_q[rd_ptr_q][7:0];
  assign byte_pad   = mem_q[rd_ptr_q][8];
  assign fifo_level = level_q;

  assign sym_hs  = sym_valid && sym_ready;
  assign byte_hs = byte_valid && byte_ready;
  assign pop     = byte_hs;

  always_comb begin
    state_d    = state_q;
    hold_nib_d = hold_nib_q;
    push       = 1'b0;
    push_data  = 8'h00;
    push_pad   = 1'b0;
    case (state_q)
      S_FIRST: begin
        if (sym_hs) begin
          hold_nib_d = sym_bits;
          state_d    = S_SECOND;
        end
      end
      S_SECOND: begin
        if (sym_hs) begin
          push      = 1'b1;
          push_data = MSB_FIRST ? {hold_nib_q, sym_bits} : {sym_bits, hold_nib_q};
          state_d   = S_FIRST;
        end
`ifdef QAM_PACK_FLUSH_EN
        // A completing symbol takes priority; a flush against a full FIFO
        // simply waits for the requester to keep flush asserted.
        else if (flush && not_full) begin
          push      = 1'b1;
          push_pad  = 1'b1;
          push_data = MSB_FIRST ? {hold_nib_q, 4'h0} : {4'h0, hold_nib_q};
          state_d   = S_FIRST;
        end
`endif
      end
      default: state_d = S_FIRST;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_pad, push_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FIRST;
      hold_nib_q <= 4'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      // Cleared so the head is a defined 0x00 before the first write.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      hold_nib_q <= hold_nib_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_qam16_nibble_packer.sv
module tb_qam16_nibble_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sym_valid;
  logic       sym_ready;
  logic [3:0] sym_bits;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] byte_data;
  logic       byte_pad;
  logic [2:0] fifo_level;
  logic       flush;

  logic       l_sym_valid;
  logic       l_sym_ready;
  logic [3:0] l_sym_bits;
  logic       l_byte_valid;
  logic       l_byte_ready;
  logic [7:0] l_byte_data;
  logic       l_byte_pad;
  logic [2:0] l_fifo_level;

  int nvec = 0;
  int nmis = 0;

  logic [3:0] nibs [10];
  logic [7:0] fill_exp [5];
  logic [7:0] exp_q [$];
  logic [7:0] head_exp;
  int         idx;
  logic       acc;

  always #5 clk = ~clk;

  qam16_nibble_packer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_bits   (sym_bits),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_pad   (byte_pad),
`ifdef QAM_PACK_FLUSH_EN
    .flush      (flush),
`endif
    .fifo_level (fifo_level)
  );

  qam16_nibble_packer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_valid  (l_sym_valid),
    .sym_ready  (l_sym_ready),
    .sym_bits   (l_sym_bits),
    .byte_valid (l_byte_valid),
    .byte_ready (l_byte_ready),
    .byte_data  (l_byte_data),
    .byte_pad   (l_byte_pad),
`ifdef QAM_PACK_FLUSH_EN
    .flush      (1'b0),
`endif
    .fifo_level (l_fifo_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] nib(input int i);
    return 4'((i * 5 + 3) % 16);
  endfunction

  initial begin
    rst_n        = 1'b0;
    sym_valid    = 1'b0;
    sym_bits     = 4'h0;
    byte_ready   = 1'b0;
    flush        = 1'b0;
    l_sym_valid  = 1'b0;
    l_sym_bits   = 4'h0;
    l_byte_ready = 1'b0;
    for (int i = 0; i < 10; i++) nibs[i] = 4'(i + 1);
    fill_exp[0] = 8'h12; fill_exp[1] = 8'h34; fill_exp[2] = 8'h56;
    fill_exp[3] = 8'h78; fill_exp[4] = 8'h9A;

    // Reset state
    #12;
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_data",  32'(byte_data),  32'h00);
    chk("rst_byte_pad",   32'(byte_pad),   32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_sym_ready",  32'(sym_ready),  32'd1);
    chk("rst_lsb_valid",  32'(l_byte_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // MSB_FIRST=1 streaming with byte_ready=1
    byte_ready = 1'b1;
    sym_valid  = 1'b1;
    sym_bits   = 4'h3; tick();
    chk("msb_no_byte_after_first", 32'(byte_valid), 32'd0);
    sym_bits   = 4'hA; tick();
    chk("msb_valid_3a", 32'(byte_valid), 32'd1);
    chk("msb_data_3a",  32'(byte_data),  32'h3A);
    chk("msb_pad_3a",   32'(byte_pad),   32'd0);
    sym_bits   = 4'hF; tick();
    chk("msb_popped_3a", 32'(fifo_level), 32'd0);
    sym_bits   = 4'h0; tick();
    chk("msb_valid_f0", 32'(byte_valid), 32'd1);
    chk("msb_data_f0",  32'(byte_data),  32'hF0);
    sym_valid  = 1'b0; tick();
    chk("msb_empty", 32'(byte_valid), 32'd0);

    // MSB_FIRST=0 instance
    l_sym_valid = 1'b1;
    l_sym_bits  = 4'h3; tick();
    l_sym_bits  = 4'hA; tick();
    l_sym_valid = 1'b0;
    chk("lsb_valid_a3", 32'(l_byte_valid), 32'd1);
    chk("lsb_data_a3",  32'(l_byte_data),  32'hA3);

    // Fill with byte_ready=0: 9 nibbles accepted, 10th stalls
    byte_ready = 1'b0;
    sym_valid  = 1'b1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      sym_bits = nibs[idx];
      acc = sym_ready;
      tick();
      if (acc && idx < 9) idx++;
    end
    chk("fill_accepted",  32'(idx),        32'd9);
    chk("fill_sym_ready", 32'(sym_ready),  32'd0);
    chk("fill_level",     32'(fifo_level), 32'd4);
    chk("fill_head",      32'(byte_data),  32'h12);
    chk("fill_stable_sym_bits", 32'(sym_bits), 32'hA);

    // Drain; the held 10th nibble completes byte 5 during the drain
    byte_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", 32'(byte_valid), 32'd1);
      chk("drain_data",  32'(byte_data),  32'(fill_exp[k]));
      acc = sym_valid && sym_ready;
      tick();
      if (acc) sym_valid = 1'b0;
      if (k == 1) chk("drain_pushpop_level", 32'(fifo_level), 32'd3);
    end
    chk("drain_empty", 32'(fifo_level), 32'd0);

    // Level 2, simultaneous push/pop over 12 bytes with pointer wrap
    byte_ready = 1'b0;
    sym_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sym_bits = nib(i);
      if (i % 2 == 1) exp_q.push_back({nib(i - 1), nib(i)});
      tick();
    end
    chk("pp_level_start", 32'(fifo_level), 32'd2);
    for (int i = 4; i < 24; i++) begin
      sym_bits   = nib(i);
      byte_ready = (i % 2 == 1);
      if (byte_ready) begin
        head_exp = exp_q.pop_front();
        chk("pp_order", 32'(byte_data), 32'(head_exp));
        exp_q.push_back({nib(i - 1), nib(i)});
      end
      tick();
      if (i % 2 == 1) chk("pp_level_2", 32'(fifo_level), 32'd2);
    end
    sym_valid  = 1'b0;
    byte_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      head_exp = exp_q.pop_front();
      chk("pp_tail_order", 32'(byte_data), 32'(head_exp));
      tick();
    end
    chk("pp_empty", 32'(fifo_level), 32'd0);

    // Reset mid-operation discards the FIFO and the held nibble
    byte_ready = 1'b0;
    sym_valid  = 1'b1;
    sym_bits   = 4'hE; tick();
    sym_bits   = 4'hD; tick();
    sym_bits   = 4'h7; tick();
    sym_valid  = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_data",  32'(byte_data),  32'h00);
    chk("mid_rst_ready", 32'(sym_ready),  32'd1);
    #1 rst_n = 1'b1;
    sym_valid = 1'b1;
    sym_bits  = 4'h1; tick();
    sym_bits  = 4'h2; tick();
    sym_valid = 1'b0;
    chk("post_rst_level", 32'(fifo_level), 32'd1);
    chk("post_rst_data",  32'(byte_data),  32'h12);
    byte_ready = 1'b1; tick();
    byte_ready = 1'b0;
    chk("post_rst_empty", 32'(fifo_level), 32'd0);

`ifdef QAM_PACK_FLUSH_EN
    sym_valid = 1'b1;
    sym_bits  = 4'h5; tick();
    sym_valid = 1'b0;
    flush     = 1'b1; tick();
    flush     = 1'b0;
    chk("flush_valid", 32'(byte_valid), 32'd1);
    chk("flush_data",  32'(byte_data),  32'h50);
    chk("flush_pad",   32'(byte_pad),   32'd1);
    byte_ready = 1'b1; tick();
    byte_ready = 1'b0;
    flush      = 1'b1; tick(); tick();
    flush      = 1'b0;
    chk("flush_first_none", 32'(fifo_level), 32'd0);
    sym_valid = 1'b1;
    sym_bits  = 4'h5; tick();
    sym_bits  = 4'hC;
    flush     = 1'b1; tick();
    flush     = 1'b0;
    sym_valid = 1'b0;
    tick();
    chk("flush_hs_level", 32'(fifo_level), 32'd1);
    chk("flush_hs_data",  32'(byte_data),  32'h5C);
    chk("flush_hs_pad",   32'(byte_pad),   32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
